// File: rtl/distcalc_pkg.sv
// -----------------------------------------------------------------------------
// distcalc_pkg
// Shared definitions for the distance pair scheduler and the redundancy table
// builder that will consume its output.
//   - DEF_WORD_WIDTH / DEF_DIST_WIDTH : default widths of config words and dr
//   - sched_state_e                   : scheduler FSM encoding
//   - cfg_is_legal()                  : window/stride legality rule
// -----------------------------------------------------------------------------
package distcalc_pkg;

  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_DIST_WIDTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // A configuration is usable when the window has at least two taps per side,
  // the stride is non-zero, the window fits inside the output map and every
  // kernel index 0..fw*fw-1 is representable in word_width bits.
  // Arguments are zero-extended config words so one function serves any
  // word width up to 32 bits.
  function automatic logic cfg_is_legal(
    input logic [31:0] ow,
    input logic [31:0] fw,
    input logic [31:0] st,
    input int          word_width
  );
    logic [63:0] taps;
    logic [63:0] index_space;
    taps        = 64'(fw) * 64'(fw);
    index_space = 64'd1 << word_width;
    return !((fw < 32'd2) || (st == 32'd0) || (fw > ow) || (taps > index_space));
  endfunction

endpackage

// File: rtl/distance_pair_scheduler_distcalc.sv
// -----------------------------------------------------------------------------
// DistanceCalculator
// Purely combinational distance between two kernel indices of an fw x fw
// window placed on an ow-wide output map with stride st:
//   dr = ((ow-fw)*(idx2/fw - idx1/fw) + (idx2-idx1)) / st
// Result is truncated to DIST_WIDTH bits.
// Ports:
//   ow_i, fw_i, st_i  : window configuration (WORD_WIDTH)
//   idx1_i, idx2_i    : kernel indices, idx2_i expected above idx1_i
//   dr_o              : distance (DIST_WIDTH)
//   except_o          : configuration or index ordering is unusable
// -----------------------------------------------------------------------------
module DistanceCalculator #(
  parameter int WORD_WIDTH = 8,
  parameter int DIST_WIDTH = 7
) (
  input  logic [WORD_WIDTH-1:0] ow_i,
  input  logic [WORD_WIDTH-1:0] fw_i,
  input  logic [WORD_WIDTH-1:0] st_i,
  input  logic [WORD_WIDTH-1:0] idx1_i,
  input  logic [WORD_WIDTH-1:0] idx2_i,
  output logic [DIST_WIDTH-1:0] dr_o,
  output logic                  except_o
);

  // Product of two words plus one word needs one extra bit of headroom.
  localparam int PW = 2 * WORD_WIDTH + 1;

  logic [WORD_WIDTH-1:0] row1;
  logic [WORD_WIDTH-1:0] row2;
  logic [WORD_WIDTH-1:0] row_delta;
  logic [WORD_WIDTH-1:0] col_span;
  logic [WORD_WIDTH-1:0] idx_delta;
  logic [PW-1:0]         numer;

  always_comb begin
    except_o = (fw_i == '0) || (st_i == '0) || (fw_i > ow_i) || (idx2_i <= idx1_i);

    // Divisions are guarded so an unusable config never divides by zero.
    row1 = '0;
    row2 = '0;
    if (fw_i != '0) begin
      row1 = idx1_i / fw_i;
      row2 = idx2_i / fw_i;
    end

    row_delta = row2 - row1;
    col_span  = ow_i - fw_i;
    idx_delta = idx2_i - idx1_i;
    numer     = PW'(col_span) * PW'(row_delta) + PW'(idx_delta);

    dr_o = '0;
    if (st_i != '0) begin
      dr_o = DIST_WIDTH'(numer / PW'(st_i));
    end
  end

endmodule

// File: rtl/distance_pair_scheduler.sv
// -----------------------------------------------------------------------------
// distance_pair_scheduler
// Walks every unordered kernel-index pair (idx1 < idx2) of an fw x fw window,
// idx1 outer and idx2 inner, and streams (idx1, idx2, dr) one pair per cycle
// over a valid/ready interface.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   start                    : begin a scan (only honoured in IDLE)
//   cfg_ow, cfg_fw, cfg_st   : configuration, latched on an accepted start
//   abort                    : drop the scan, return to IDLE without done
//   busy                     : scan in progress (RUN or DONE)
//   cfg_err                  : one-cycle pulse for a start with illegal config
//   out_valid / out_ready    : pair stream handshake
//   out_idx1, out_idx2       : pair indices, out_idx2 > out_idx1
//   out_dr                   : distance of the presented pair
//   out_last                 : presented pair is the final (K-2, K-1)
//   done                     : one-cycle pulse after the final pair is taken
// -----------------------------------------------------------------------------
module distance_pair_scheduler
  import distcalc_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DIST_WIDTH = DEF_DIST_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_ow,
  input  logic [WORD_WIDTH-1:0] cfg_fw,
  input  logic [WORD_WIDTH-1:0] cfg_st,
  input  logic                  abort,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_idx1,
  output logic [WORD_WIDTH-1:0] out_idx2,
  output logic [DIST_WIDTH-1:0] out_dr,
  output logic                  out_last,
  output logic                  done
);

  sched_state_e state_q, state_d;

  logic [WORD_WIDTH-1:0] ow_q,   ow_d;
  logic [WORD_WIDTH-1:0] fw_q,   fw_d;
  logic [WORD_WIDTH-1:0] st_q,   st_d;
  logic [WORD_WIDTH-1:0] kmax_q, kmax_d;   // K-1, the largest kernel index
  logic [WORD_WIDTH-1:0] idx1_q, idx1_d;
  logic [WORD_WIDTH-1:0] idx2_q, idx2_d;
  logic [DIST_WIDTH-1:0] dr_q,   dr_d;
  logic                  last_q, last_d;
  logic                  cfg_err_q, cfg_err_d;

  // Next-pair mux and the calculator operands it drives.
  logic                  cfg_legal;
  logic [WORD_WIDTH-1:0] cfg_kmax;
  logic [WORD_WIDTH-1:0] nxt_idx1;
  logic [WORD_WIDTH-1:0] nxt_idx2;
  logic [WORD_WIDTH-1:0] nxt_kmax;
  logic                  nxt_last;
  logic [WORD_WIDTH-1:0] calc_ow;
  logic [WORD_WIDTH-1:0] calc_fw;
  logic [WORD_WIDTH-1:0] calc_st;
  logic [DIST_WIDTH-1:0] calc_dr;

  assign cfg_legal = cfg_is_legal(32'(cfg_ow), 32'(cfg_fw), 32'(cfg_st), WORD_WIDTH);

  // fw*fw may equal 2^WORD_WIDTH exactly; the wrap to zero followed by the
  // decrement still lands on the correct K-1.
  assign cfg_kmax = cfg_fw * cfg_fw - WORD_WIDTH'(1);

  // In IDLE the calculator sees the incoming config so pair (0,1) and its
  // distance can be loaded on the same edge that accepts start. In RUN it
  // sees the latched config and the successor of the presented pair.
  always_comb begin
    calc_ow  = ow_q;
    calc_fw  = fw_q;
    calc_st  = st_q;
    nxt_kmax = kmax_q;
    nxt_idx1 = idx1_q;
    nxt_idx2 = idx2_q + WORD_WIDTH'(1);

    if (state_q == ST_IDLE) begin
      calc_ow  = cfg_ow;
      calc_fw  = cfg_fw;
      calc_st  = cfg_st;
      nxt_kmax = cfg_kmax;
      nxt_idx1 = '0;
      nxt_idx2 = WORD_WIDTH'(1);
    end else if (idx2_q == kmax_q) begin
      // Row of the pair triangle exhausted: advance idx1, restart idx2 above it.
      nxt_idx1 = idx1_q + WORD_WIDTH'(1);
      nxt_idx2 = idx1_q + WORD_WIDTH'(2);
    end

    nxt_last = (nxt_idx2 == nxt_kmax) && (nxt_idx1 == nxt_kmax - WORD_WIDTH'(1));
  end

  DistanceCalculator #(
    .WORD_WIDTH (WORD_WIDTH),
    .DIST_WIDTH (DIST_WIDTH)
  ) u_distcalc (
    .ow_i     (calc_ow),
    .fw_i     (calc_fw),
    .st_i     (calc_st),
    .idx1_i   (nxt_idx1),
    .idx2_i   (nxt_idx2),
    .dr_o     (calc_dr),
    .except_o ()            // legality is already screened at start
  );

  // Next-state and register-update logic.
  always_comb begin
    state_d   = state_q;
    ow_d      = ow_q;
    fw_d      = fw_q;
    st_d      = st_q;
    kmax_d    = kmax_q;
    idx1_d    = idx1_q;
    idx2_d    = idx2_q;
    dr_d      = dr_q;
    last_d    = last_q;
    cfg_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_legal) begin
            state_d = ST_RUN;
            ow_d    = cfg_ow;
            fw_d    = cfg_fw;
            st_d    = cfg_st;
            kmax_d  = cfg_kmax;
            idx1_d  = nxt_idx1;
            idx2_d  = nxt_idx2;
            dr_d    = calc_dr;
            last_d  = nxt_last;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        // abort wins over a handshake in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end else if (out_ready) begin
          if (last_q) begin
            state_d = ST_DONE;
            last_d  = 1'b0;
          end else begin
            idx1_d = nxt_idx1;
            idx2_d = nxt_idx2;
            dr_d   = calc_dr;
            last_d = nxt_last;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ow_q      <= '0;
      fw_q      <= '0;
      st_q      <= '0;
      kmax_q    <= '0;
      idx1_q    <= '0;
      idx2_q    <= '0;
      dr_q      <= '0;
      last_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ow_q      <= ow_d;
      fw_q      <= fw_d;
      st_q      <= st_d;
      kmax_q    <= kmax_d;
      idx1_q    <= idx1_d;
      idx2_q    <= idx2_d;
      dr_q      <= dr_d;
      last_q    <= last_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_valid = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign cfg_err   = cfg_err_q;
  assign out_idx1  = idx1_q;
  assign out_idx2  = idx2_q;
  assign out_dr    = dr_q;
  assign out_last  = last_q && (state_q == ST_RUN);

endmodule

// File: tb/tb_distance_pair_scheduler.sv
// -----------------------------------------------------------------------------
// tb_distance_pair_scheduler
// Scenario tasks drive the scheduler; expected pairs come from a behavioural
// model pushed into a scoreboard queue at start and popped on each handshake.
// -----------------------------------------------------------------------------
module tb_distance_pair_scheduler;

  localparam int WW = 8;
  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          out_ready;
  logic [WW-1:0] cfg_ow;
  logic [WW-1:0] cfg_fw;
  logic [WW-1:0] cfg_st;
  logic          busy;
  logic          cfg_err;
  logic          out_valid;
  logic [WW-1:0] out_idx1;
  logic [WW-1:0] out_idx2;
  logic [DW-1:0] out_dr;
  logic          out_last;
  logic          done;

  typedef struct packed {
    logic [WW-1:0] i1;
    logic [WW-1:0] i2;
    logic [DW-1:0] dr;
    logic          last;
  } pair_t;

  pair_t sb[$];
  pair_t cap[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  distance_pair_scheduler #(
    .WORD_WIDTH (WW),
    .DIST_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_ow    (cfg_ow),
    .cfg_fw    (cfg_fw),
    .cfg_st    (cfg_st),
    .abort     (abort),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx1  (out_idx1),
    .out_idx2  (out_idx2),
    .out_dr    (out_dr),
    .out_last  (out_last),
    .done      (done)
  );

  function automatic pair_t mk(input int i1, input int i2, input int dr, input logic last);
    pair_t p;
    p.i1   = WW'(i1);
    p.i2   = WW'(i2);
    p.dr   = DW'(dr);
    p.last = last;
    return p;
  endfunction

  function automatic pair_t observed();
    pair_t p;
    p.i1   = out_idx1;
    p.i2   = out_idx2;
    p.dr   = out_dr;
    p.last = out_last;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: every pair of the scan in order, dr modulo 2^DW.
  task automatic push_scan(input int ow, input int fw, input int st);
    int k;
    int d;
    k = fw * fw;
    for (int i1 = 0; i1 <= k - 2; i1++) begin
      for (int i2 = i1 + 1; i2 <= k - 1; i2++) begin
        d = ((ow - fw) * (i2 / fw - i1 / fw) + (i2 - i1)) / st;
        sb.push_back(mk(i1, i2, d % (1 << DW), (i1 == k - 2) && (i2 == k - 1)));
      end
    end
  endtask

  // Holds start for exactly one sampling edge; returns in the cycle after it.
  task automatic drive_start(input int ow, input int fw, input int st);
    cfg_ow = WW'(ow);
    cfg_fw = WW'(fw);
    cfg_st = WW'(st);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Full-throughput scan with timing checks; returns the cycle index (0 = the
  // cycle after start) at which done was observed.
  task automatic run_full_scan(input int ow, input int fw, input int st, output int done_at);
    int    cyc;
    int    n;
    int    budget;
    pair_t e;
    pair_t o;
    sb.delete();
    cap.delete();
    push_scan(ow, fw, st);
    budget    = sb.size() + 10;
    out_ready = 1'b1;
    drive_start(ow, fw, st);
    cyc = 0;
    n   = 0;
    while (sb.size() > 0 && cyc < budget) begin
      if (out_valid === 1'b1) begin
        e = sb.pop_front();
        o = observed();
        cap.push_back(o);
        $display("pair %0d cycle %0d: idx1=%0d idx2=%0d dr=%0d last=%0d", n, cyc, o.i1, o.i2, o.dr, o.last);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL pair_value n=%0d got (%0d,%0d,dr=%0d,last=%0d) want (%0d,%0d,dr=%0d,last=%0d)",
                   n, o.i1, o.i2, o.dr, o.last, e.i1, e.i2, e.dr, e.last);
        end
        checks++;
        if (cyc != n) begin
          errors++;
          $display("FAIL pair_timing n=%0d got cycle %0d want cycle %0d", n, cyc, n);
        end
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL early_done n=%0d got done=%b want 0", n, done);
        end
        n++;
      end else begin
        checks++;
        errors++;
        $display("FAIL valid_gap cycle %0d got out_valid=%b want 1", cyc, out_valid);
      end
      tick();
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scan_timeout got %0d pairs left want 0", sb.size());
    end
    done_at = cyc;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%b busy=%b valid=%b want 1 1 0", done, busy, out_valid);
    end
    $display("done observed at cycle %0d", cyc);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_ow = '0; cfg_fw = '0; cfg_st = '0;
    tick();
    tick();
    checks++;
    if ({busy, cfg_err, out_valid, out_idx1, out_idx2, out_dr, out_last, done} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b err=%b valid=%b idx=(%0d,%0d) dr=%0d last=%b done=%b want all 0",
               busy, cfg_err, out_valid, out_idx1, out_idx2, out_dr, out_last, done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, out_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b valid=%b done=%b want 0", busy, out_valid, done);
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_scan_3x3();
    int d;
    run_full_scan(20, 3, 1, d);
    checks++;
    if (d != 36) begin
      errors++;
      $display("FAIL done_time_3x3 got cycle %0d want 36", d);
    end
    checks++;
    if (cap.size() == 36) begin
      if (cap[0] !== mk(0, 1, 1, 1'b0) || cap[3] !== mk(0, 4, 21, 1'b0) || cap[35] !== mk(7, 8, 1, 1'b1)) begin
        errors++;
        $display("FAIL spot_3x3 got dr0=%0d dr3=%0d dr35=%0d last35=%b want 1 21 1 1",
                 cap[0].dr, cap[3].dr, cap[35].dr, cap[35].last);
      end
    end else begin
      errors++;
      $display("FAIL count_3x3 got %0d pairs want 36", cap.size());
    end
  endtask

  task automatic test_scan_5x5();
    int d;
    run_full_scan(42, 5, 2, d);
    checks++;
    if (d != 300) begin
      errors++;
      $display("FAIL done_time_5x5 got cycle %0d want 300", d);
    end
    checks++;
    if (cap.size() == 300) begin
      if (cap[11] !== mk(0, 12, 43, 1'b0)) begin
        errors++;
        $display("FAIL spot_5x5 got (%0d,%0d,dr=%0d) want (0,12,dr=43)", cap[11].i1, cap[11].i2, cap[11].dr);
      end
    end else begin
      errors++;
      $display("FAIL count_5x5 got %0d pairs want 300", cap.size());
    end
  endtask

  task automatic test_backpressure();
    pair_t e;
    sb.delete();
    push_scan(20, 3, 1);
    out_ready = 1'b1;
    drive_start(20, 3, 1);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || observed() !== e) begin
      errors++;
      $display("FAIL bp_first got valid=%b (%0d,%0d) want 1 (0,1)", out_valid, out_idx1, out_idx2);
    end
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      $display("stall %0d: valid=%b idx1=%0d idx2=%0d dr=%0d", c, out_valid, out_idx1, out_idx2, out_dr);
      checks++;
      if (out_valid !== 1'b1 || observed() !== sb[0] || observed() !== mk(0, 2, 2, 1'b0)) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b (%0d,%0d,dr=%0d) want 1 (0,2,dr=2)",
                 c, out_valid, out_idx1, out_idx2, out_dr);
      end
      tick();
    end
    out_ready = 1'b1;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || observed() !== e) begin
      errors++;
      $display("FAIL bp_release got (%0d,%0d,dr=%0d) want (0,2,dr=2)", out_idx1, out_idx2, out_dr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || observed() !== sb[0] || observed() !== mk(0, 3, 20, 1'b0)) begin
      errors++;
      $display("FAIL bp_next got (%0d,%0d,dr=%0d) want (0,3,dr=20)", out_idx1, out_idx2, out_dr);
    end
    $display("after release: idx1=%0d idx2=%0d dr=%0d", out_idx1, out_idx2, out_dr);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_cleanup got valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_illegal_cfg();
    int cfgs [4][3] = '{'{20, 1, 1}, '{20, 3, 0}, '{4, 5, 1}, '{20, 17, 1}};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_start(cfgs[i][0], cfgs[i][1], cfgs[i][2]);
      $display("illegal ow=%0d fw=%0d st=%0d: cfg_err=%b busy=%b valid=%b",
               cfgs[i][0], cfgs[i][1], cfgs[i][2], cfg_err, busy, out_valid);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_pulse cfg %0d got err=%b busy=%b valid=%b want 1 0 0", i, cfg_err, busy, out_valid);
      end
      tick();
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_width cfg %0d got err=%b busy=%b valid=%b want 0 0 0", i, cfg_err, busy, out_valid);
      end
    end
    // Largest legal window: 16x16 uses the full 8-bit index space.
    drive_start(16, 16, 1);
    $display("legal ow=16 fw=16 st=1: cfg_err=%b busy=%b", cfg_err, busy);
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1 || observed() !== mk(0, 1, 1, 1'b0)) begin
      errors++;
      $display("FAIL fw16_legal got err=%b busy=%b (%0d,%0d,dr=%0d) want 0 1 (0,1,dr=1)",
               cfg_err, busy, out_idx1, out_idx2, out_dr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    pair_t e;
    int    d;
    sb.delete();
    push_scan(20, 3, 1);
    out_ready = 1'b1;
    drive_start(20, 3, 1);
    for (int n = 0; n < 5; n++) begin
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || observed() !== e) begin
        errors++;
        $display("FAIL abort_pre n=%0d got (%0d,%0d) want (%0d,%0d)", n, out_idx1, out_idx2, e.i1, e.i2);
      end
      tick();
    end
    $display("abort on pair 5: idx1=%0d idx2=%0d", out_idx1, out_idx2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got valid=%b busy=%b done=%b want 0 0 0", out_valid, busy, done);
    end
    run_full_scan(20, 3, 1, d);
    checks++;
    if (d != 36 || cap.size() == 0 || cap[0] !== mk(0, 1, 1, 1'b0)) begin
      errors++;
      $display("FAIL abort_restart got done cycle %0d pairs %0d want 36 from (0,1)", d, cap.size());
    end
  endtask

  task automatic test_reset_mid_scan();
    pair_t e;
    sb.delete();
    push_scan(42, 5, 2);
    out_ready = 1'b1;
    drive_start(42, 5, 2);
    for (int n = 0; n < 15; n++) begin
      // A second start with a different config must not disturb the scan.
      start = (n == 4);
      if (n == 4) begin
        cfg_ow = 8'd20; cfg_fw = 8'd3; cfg_st = 8'd1;
      end
      e = sb.pop_front();
      $display("mid pair %0d: idx1=%0d idx2=%0d dr=%0d", n, out_idx1, out_idx2, out_dr);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || observed() !== e) begin
        errors++;
        $display("FAIL mid_scan n=%0d got (%0d,%0d,dr=%0d) want (%0d,%0d,dr=%0d)",
                 n, out_idx1, out_idx2, out_dr, e.i1, e.i2, e.dr);
      end
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, cfg_err, out_valid, out_idx1, out_idx2, out_dr, out_last, done} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b valid=%b idx=(%0d,%0d) dr=%0d last=%b done=%b want all 0",
               busy, out_valid, out_idx1, out_idx2, out_dr, out_last, done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got busy=%b valid=%b want 0 0", busy, out_valid);
    end
    $display("reset mid-scan: outputs cleared");
  endtask

  initial begin
    test_reset();
    test_scan_3x3();
    test_scan_5x5();
    test_backpressure();
    test_illegal_cfg();
    test_abort();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
